// File: rtl/vid_pkg.sv
// Shared definitions for the video stream generator: default 640x480@60
// timing constants, counter width, stream FSM encoding and sync level helper.
package vid_pkg;

  localparam int unsigned CNT_W = 12;

  localparam logic [CNT_W-1:0] DEF_H_DISP  = 12'd640;
  localparam logic [CNT_W-1:0] DEF_H_SYNC  = 12'd96;
  localparam logic [CNT_W-1:0] DEF_H_BACK  = 12'd48;
  localparam logic [CNT_W-1:0] DEF_H_FRONT = 12'd16;

  localparam logic [CNT_W-1:0] DEF_V_DISP  = 12'd480;
  localparam logic [CNT_W-1:0] DEF_V_SYNC  = 12'd2;
  localparam logic [CNT_W-1:0] DEF_V_BACK  = 12'd33;
  localparam logic [CNT_W-1:0] DEF_V_FRONT = 12'd10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Drive a sync line to its asserted level or to the opposite level.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with stage-0 decode of sync, active
// region and last-position flags. Counters sit at 0 whenever run is low.
module vid_timing_cnt
  import vid_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_DISP  = DEF_H_DISP,
  parameter logic [CNT_W-1:0] V_DISP  = DEF_V_DISP,
  parameter logic [CNT_W-1:0] H_SYNC  = DEF_H_SYNC,
  parameter logic [CNT_W-1:0] H_BACK  = DEF_H_BACK,
  parameter logic [CNT_W-1:0] H_FRONT = DEF_H_FRONT,
  parameter logic [CNT_W-1:0] V_SYNC  = DEF_V_SYNC,
  parameter logic [CNT_W-1:0] V_BACK  = DEF_V_BACK,
  parameter logic [CNT_W-1:0] V_FRONT = DEF_V_FRONT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic hs_p0,
  output logic vs_p0,
  output logic de_p0,
  output logic last_p0
);

  localparam logic [CNT_W-1:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [CNT_W-1:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST    = H_TOTAL - 12'd1;
  localparam logic [CNT_W-1:0] V_LAST    = V_TOTAL - 12'd1;
  localparam logic [CNT_W-1:0] H_ACT_BEG = H_SYNC + H_BACK;
  localparam logic [CNT_W-1:0] H_ACT_END = H_ACT_BEG + H_DISP;
  localparam logic [CNT_W-1:0] V_ACT_BEG = V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] V_ACT_END = V_ACT_BEG + V_DISP;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_act;
  logic             v_act;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 0: decode straight from the counters.
  assign h_act   = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_act   = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign hs_p0   = (h_cnt < H_SYNC);
  assign vs_p0   = (v_cnt < V_SYNC);
  assign de_p0   = h_act && v_act;
  assign last_p0 = h_wrap && v_wrap;

endmodule

// File: rtl/video_stream_gen.sv
// Video timing generator pulling pixels from a FIFO: stream FSM, FIFO read
// strobe, one-cycle output register stage and sticky underflow flag.
module video_stream_gen
  import vid_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_DISP   = DEF_H_DISP,
  parameter logic [CNT_W-1:0] V_DISP   = DEF_V_DISP,
  parameter logic [CNT_W-1:0] H_SYNC   = DEF_H_SYNC,
  parameter logic [CNT_W-1:0] H_BACK   = DEF_H_BACK,
  parameter logic [CNT_W-1:0] H_FRONT  = DEF_H_FRONT,
  parameter logic [CNT_W-1:0] V_SYNC   = DEF_V_SYNC,
  parameter logic [CNT_W-1:0] V_BACK   = DEF_V_BACK,
  parameter logic [CNT_W-1:0] V_FRONT  = DEF_V_FRONT,
  parameter logic             SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_err,
  output logic       pix_rd,
  input  logic [7:0] pix_data,
  input  logic       pix_empty,
  output logic       Y_hsync,
  output logic       Y_vsync,
  output logic       Y_de,
  output logic [7:0] Y_data,
  output logic       frame_done,
  output logic       busy,
  output logic       underflow
);

  state_t state;
  state_t state_nxt;
  logic   active;
  logic   hs_p0;
  logic   vs_p0;
  logic   de_p0;
  logic   last_p0;
  logic   vld_p1;
  logic   uf_p1;
  logic   uf_set;

  assign active = (state != IDLE);
  assign busy   = active;

  vid_timing_cnt #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_FRONT (V_FRONT)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (active),
    .hs_p0   (hs_p0),
    .vs_p0   (vs_p0),
    .de_p0   (de_p0),
    .last_p0 (last_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A frame in progress always runs to its last position; en only decides
  // what happens at the wrap.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (en) state_nxt = RUN;
      RUN: begin
        if (last_p0)  state_nxt = en ? RUN : IDLE;
        else if (!en) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (last_p0) state_nxt = en ? RUN : IDLE;
        else if (en) state_nxt = RUN;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Read is issued even into an empty FIFO so raster timing never slips.
  assign pix_rd = active && de_p0;
  assign uf_set = pix_rd && pix_empty;

  // Stage 0 -> stage 1: register everything so it lines up with pix_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_hsync    <= ~SYNC_POL;
      Y_vsync    <= ~SYNC_POL;
      vld_p1     <= 1'b0;
      uf_p1      <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      Y_hsync    <= sync_level(active && hs_p0, SYNC_POL);
      Y_vsync    <= sync_level(active && vs_p0, SYNC_POL);
      vld_p1     <= pix_rd;
      uf_p1      <= uf_set;
      frame_done <= active && last_p0;
      if (uf_set)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  // pix_data arrives in the stage-1 cycle; a starved read blanks its pixel.
  assign Y_de   = vld_p1;
  assign Y_data = (vld_p1 && !uf_p1) ? pix_data : 8'h00;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen on a 7x6 raster (4x3 active) with a
// FIFO model feeding a pixel scoreboard.
module tb_video_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr_err;
  logic       pix_rd;
  logic [7:0] pix_data;
  logic       pix_empty;
  logic       Y_hsync;
  logic       Y_vsync;
  logic       Y_de;
  logic [7:0] Y_data;
  logic       frame_done;
  logic       busy;
  logic       underflow;

  video_stream_gen #(
    .H_DISP   (12'd4),
    .V_DISP   (12'd3),
    .H_SYNC   (12'd1),
    .H_BACK   (12'd1),
    .H_FRONT  (12'd1),
    .V_SYNC   (12'd1),
    .V_BACK   (12'd1),
    .V_FRONT  (12'd1),
    .SYNC_POL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr_err    (clr_err),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .pix_empty  (pix_empty),
    .Y_hsync    (Y_hsync),
    .Y_vsync    (Y_vsync),
    .Y_de       (Y_de),
    .Y_data     (Y_data),
    .frame_done (frame_done),
    .busy       (busy),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_fd = -1;
  int         de_cnt = 0;
  int         hs_cnt = 0;
  int         vs_cnt = 0;
  int         c0 = 0;
  logic [7:0] nxt = 8'h10;
  logic       uf_exp = 1'b0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "pix_rd"},     pix_rd,     32'd0);
    chk({pfx, "Y_de"},       Y_de,       32'd0);
    chk({pfx, "Y_data"},     Y_data,     32'd0);
    chk({pfx, "Y_hsync"},    Y_hsync,    32'd1);
    chk({pfx, "Y_vsync"},    Y_vsync,    32'd1);
    chk({pfx, "frame_done"}, frame_done, 32'd0);
    chk({pfx, "busy"},       busy,       32'd0);
    chk({pfx, "underflow"},  underflow,  32'd0);
  endtask

  // One clock: FIFO model answers the read, then outputs are sampled 1ns later.
  task automatic step();
    logic       rd;
    logic       emp;
    logic       clr;
    logic [7:0] exp_d;
    rd  = pix_rd;
    emp = pix_empty;
    clr = clr_err;
    @(posedge clk);
    if (rd) begin
      if (emp) begin
        pix_data = 8'hEE;
        sb.push_back(8'h00);
      end else begin
        pix_data = nxt;
        sb.push_back(nxt);
        nxt = nxt + 8'd1;
      end
    end else begin
      pix_data = 8'hCC;
    end
    if (rd && emp)  uf_exp = 1'b1;
    else if (clr)   uf_exp = 1'b0;
    #1;
    cyc++;
    chk("underflow", underflow, uf_exp);
    if (Y_de) begin
      de_cnt++;
      if (sb.size() == 0) chk("sb_depth", sb.size(), 32'd1);
      else begin
        exp_d = sb.pop_front();
        chk("Y_data", Y_data, exp_d);
      end
    end else begin
      chk("Y_data_blank", Y_data, 32'd0);
    end
    if (!Y_hsync) hs_cnt++;
    if (!Y_vsync) vs_cnt++;
    if (frame_done) begin
      chk("frame_de_count", de_cnt, 32'd12);
      chk("frame_hs_count", hs_cnt, 32'd6);
      chk("frame_vs_count", vs_cnt, 32'd7);
      if (last_fd >= 0) chk("fd_period", cyc - last_fd, 32'd42);
      last_fd = cyc;
      de_cnt = 0;
      hs_cnt = 0;
      vs_cnt = 0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_fd(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < budget);
    chk("fd_reached", frame_done, 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    int n = 0;
    while (!pix_rd && n < budget) begin
      step();
      n++;
    end
    chk("rd_reached", pix_rd, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    clr_err   = 1'b0;
    pix_empty = 1'b0;
    pix_data  = 8'h00;
    #12;
    chk_reset_vals("por_");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    steps(3);
    chk("idle_busy", busy, 32'd0);
    chk("idle_pix_rd", pix_rd, 32'd0);

    // Continuous streaming, clean FIFO
    en = 1'b1;
    c0 = cyc;
    step();
    chk("start_busy", busy, 32'd1);
    chk("start_hs_idle", Y_hsync, 32'd1);
    step();
    chk("first_hs", Y_hsync, 32'd0);
    chk("first_vs", Y_vsync, 32'd0);
    run_until_fd(60);
    chk("first_fd_latency", cyc - c0, 32'd43);
    step();
    chk("fd_one_cycle", frame_done, 32'd0);
    chk("wrap_vs", Y_vsync, 32'd0);

    // Starve the 2nd active pixel, then clear, then set+clear together
    wait_rd(50);
    step();
    chk("second_rd", pix_rd, 32'd1);
    pix_empty = 1'b1;
    step();
    pix_empty = 1'b0;
    chk("uf_set", underflow, 32'd1);
    steps(3);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("uf_cleared", underflow, 32'd0);
    wait_rd(50);
    pix_empty = 1'b1;
    clr_err   = 1'b1;
    step();
    pix_empty = 1'b0;
    clr_err   = 1'b0;
    chk("uf_set_wins", underflow, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    run_until_fd(60);

    // Drop en mid-frame: frame completes, then idle
    steps(20);
    en = 1'b0;
    steps(10);
    chk("stopping_busy", busy, 32'd1);
    run_until_fd(40);
    step();
    chk("stopped_busy", busy, 32'd0);
    chk("stopped_pix_rd", pix_rd, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_hs", Y_hsync, 32'd1);
      chk("idle_vs", Y_vsync, 32'd1);
      chk("idle_de", Y_de, 32'd0);
    end
    chk("sb_drained_stop", sb.size(), 32'd0);

    // Drop en at 20, restore at 30: no gap between frames
    last_fd = -1;
    en = 1'b1;
    steps(2);
    run_until_fd(60);
    steps(20);
    en = 1'b0;
    steps(10);
    en = 1'b1;
    run_until_fd(40);
    step();
    chk("no_gap_busy", busy, 32'd1);
    chk("no_gap_vs", Y_vsync, 32'd0);
    chk("no_gap_hs", Y_hsync, 32'd0);

    // Asynchronous reset in the middle of the active area
    steps(24);
    chk("pre_rst_de", Y_de, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst_");
    sb.delete();
    uf_exp  = 1'b0;
    de_cnt  = 0;
    hs_cnt  = 0;
    vs_cnt  = 0;
    last_fd = -1;
    #2;
    rst_n = 1'b1;
    c0 = cyc;
    step();
    chk("restart_busy", busy, 32'd1);
    step();
    chk("restart_hs", Y_hsync, 32'd0);
    chk("restart_vs", Y_vsync, 32'd0);
    run_until_fd(60);
    chk("restart_fd_latency", cyc - c0, 32'd43);
    chk("sb_drained_end", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- H_DISP, 12'd640, active pixels per line
- V_DISP, 12'd480, active lines per frame
- H_SYNC / H_BACK / H_FRONT, 96 / 48 / 16, horizontal sync, back porch and front porch widths
- V_SYNC / V_BACK / V_FRONT, 2 / 33 / 10, vertical sync, back porch and front porch widths
- SYNC_POL, 1'b0, asserted level of Y_hsync and Y_vsync
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- en, in, 1, stream enable
- clr_err, in, 1, clears underflow
- pix_rd, out, 1, pixel FIFO read strobe
- pix_data, in, 8, FIFO data, valid one cycle after pix_rd
- pix_empty, in, 1, FIFO empty
- Y_hsync, out, 1, line sync
- Y_vsync, out, 1, frame sync
- Y_de, out, 1, data enable
- Y_data, out, 8, pixel
- frame_done, out, 1, one-cycle pulse at end of frame
- busy, out, 1, high in RUN and STOPPING
- underflow, out, 1, sticky error flag

Function
REQ-003 Derived totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (800/525 at defaults).
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 and wrap; v_cnt SHALL increment on each h_cnt wrap, range 0..V_TOTAL-1, and wrap.
REQ-005 Line order SHALL be sync, back porch, active, front porch; the frame order SHALL be the same.
REQ-006 Stage-0 signals from counters: hs0 = h_cnt<H_SYNC; vs0 = v_cnt<V_SYNC; de0 = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-007 pix_rd SHALL equal de0 while in RUN or STOPPING, regardless of pix_empty.
REQ-008 All outputs SHALL be registered one cycle after stage 0, so Y_de aligns with the returned pix_data: total latency 1 cycle, counter to output.
REQ-009 Y_hsync/Y_vsync SHALL equal SYNC_POL when hs0/vs0 were true, else ~SYNC_POL.
REQ-010 Y_data SHALL be pix_data when Y_de=1 and no underflow occurred; otherwise 8'h00.
REQ-011 Underflow: pix_rd=1 with pix_empty=1 SHALL set underflow on the next edge and force Y_data=8'h00 for that pixel; timing SHALL continue unaffected.
REQ-012 underflow SHALL stay set until clr_err=1; if a set and clr_err happen in the same cycle, set wins.
REQ-013 FSM states:
- IDLE: counters held at 0, pix_rd=0, syncs deasserted, Y_de=0, Y_data=0.
- RUN: timing generation.
- STOPPING: as RUN, but the frame is being finished.
REQ-014 FSM transitions:
- IDLE->RUN when en=1; the first output cycle is h_cnt=0, v_cnt=0.
- RUN->STOPPING when en=0 mid-frame.
- STOPPING->RUN if en returns to 1 before the frame ends.
- RUN/STOPPING at the last pixel (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): go to IDLE if en=0, else wrap and stay in RUN.
- Frames SHALL never be truncated by en.
REQ-015 frame_done SHALL pulse for one cycle, aligned with the output cycle of the last counter position of each frame, in both RUN and STOPPING.
REQ-016 Counters SHALL be 12 bits; wrap compare SHALL use equality with TOTAL-1.

Reset
REQ-017 Asynchronous assertion of rst_n SHALL return the block to this state immediately, including mid-frame: FSM in IDLE, counters 0, pix_rd=0, Y_de=0, Y_data=8'h00, Y_hsync=Y_vsync=~SYNC_POL, frame_done=0, busy=0, underflow=0.
REQ-018 After rst_n deasserts, the first RUN cycle SHALL occur on the first edge where en=1.

Structure
REQ-019 Shared package vid_pkg SHALL hold the default 640x480@60 timing constants and the FSM state encoding (IDLE, RUN, STOPPING).
REQ-020 One sub-module, vid_timing_cnt, SHALL own h_cnt/v_cnt and hs0/vs0/de0/last-position decode. FSM, FIFO interface and output registers SHALL stay in the top.

Verification (small parameters H_DISP=4, V_DISP=3, all porches/syncs=1; H_TOTAL=7, V_TOTAL=6)
REQ-021 en=1, FIFO always non-empty, data=incrementing from 8'h10:
- 12 Y_de cycles per frame with data 10..1B in order.
- Y_hsync low 1 of every 7 cycles; Y_vsync low for 7 cycles per 42.
- frame_done every 42 cycles.
REQ-022 pix_empty=1 for the 2nd active pixel of frame 1:
- that pixel Y_data=00, underflow=1 from the next cycle onward.
- clr_err pulse clears it; simultaneous new underflow and clr_err leaves it 1.
REQ-023 en dropped at cycle 20 of a frame:
- frame completes all 12 Y_de pixels, frame_done pulses, then busy=0, pix_rd=0, syncs held deasserted.
REQ-024 en dropped at cycle 20 and restored at cycle 30:
- no IDLE gap; the next frame starts immediately after cycle 41.
REQ-025 rst_n pulsed low at cycle 25 mid-active:
- all outputs reach reset values asynchronously.
- with en=1 the next frame restarts at h_cnt=0, v_cnt=0.
REQ-026 Default parameters, one frame:
- exactly 307200 pix_rd cycles and 420000 total cycles.
- Y_de rises 144 cycles after Y_hsync assertion, on line 35.
